wrr_burst_scheduler: RTL and testbench
======================================

# wrr_burst_scheduler

Weighted round-robin scheduler that shares one downstream resource (bus port, pipeline slot) among NUM_REQ requesters. A winner holds the resource for up to `weight` accepted beats, then ownership rotates. Sits between requester agents and the resource's valid/ready port. It extends the team's single-cycle round-robin arbitration with burst ownership and a handshake.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- WT_W, 4, width of each per-requester weight field
- ID_W, $clog2(NUM_REQ), width of gnt_id
- clk  in  1  rising-edge clock
- rst_b  in  1  reset; one clock; reset is synchronous and active-low (sampled on rising clk edge)
- req  in  NUM_REQ  per-requester request level; bit i held high while requester i has beats
- weight  in  NUM_REQ*WT_W  burst credit per requester, field i at [i*WT_W +: WT_W]; quasi-static, sampled at grant start
- gnt_rdy  in  1  resource accepts the current beat
- gnt  out  NUM_REQ  one-hot owner, registered
- gnt_id  out  ID_W  encoded owner, valid when gnt_vld
- gnt_vld  out  1  = |gnt; beat offered to resource
- gnt_last  out  1  high when the current beat is the owner's final credit

## Operation
- State: IDLE, OWN. Registers: owner (ID_W), credit (WT_W), last_ptr (ID_W).
- Beat = gnt_vld & gnt_rdy.
- Arbitration: search from last_ptr+1 upward, wrapping modulo NUM_REQ; first set req bit wins. last_ptr = previous owner, so the last owner has lowest priority.
- IDLE: if |req, the next cycle enters OWN. gnt = onehot(winner), credit = weight[winner], with weight 0 treated as 1. Otherwise stay IDLE with outputs 0.
- OWN, release conditions (evaluated each cycle):
  - beat with credit==1, or
  - req[owner]==0. Any beat that same cycle is still counted by the resource, but the scheduler releases regardless.
- OWN, no release: on a beat, credit decrements by 1. Without a beat, credit holds. gnt is unchanged.
- On release:
  - last_ptr <= owner.
  - Arbitration runs the same cycle on current req, with the released owner at lowest priority.
  - If a winner exists, the next cycle is OWN with the new winner. There is no bubble.
  - Otherwise go to IDLE.
- The sole requester is re-granted immediately after release, with credit reloaded.
- gnt_last = gnt_vld & (credit==1).
- gnt_id = encoded owner. gnt is exactly one-hot or zero; it never changes mid-cycle.
- Changes to weight during OWN do not affect the current burst.

## Timing
- Reset values: gnt=0, gnt_id=0, gnt_vld=0, gnt_last=0, state=IDLE, credit=0, last_ptr=NUM_REQ-1 (requester 0 wins first).
- Request-to-grant latency: 1 cycle from IDLE (req sampled at edge N, gnt high after edge N).
- Handover latency: 0 idle cycles. The final beat accepted at edge N gives the new owner's gnt after edge N.
- gnt_rdy may be low indefinitely; the grant is held while req[owner] stays high.
- rst_b low mid-burst: at that edge all registers go to reset values. The partial burst is abandoned and nothing is retained.
- Simultaneous release and new req arriving the same cycle: the new req participates in that cycle's arbitration.

## Test plan
- Reset then req=4'b1111, weight all 2, gnt_rdy=1 -> gnt sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001. gnt_last is high on every second beat.
- weight={4,3,2,1} (req3..0), req=1111, rdy=1 -> burst lengths 1,2,3,4 for requesters 0,1,2,3 respectively, with no idle cycle between bursts.
- req=0001 only, weight0=3, rdy toggling 1,0,1,0,1 -> credit holds on rdy=0; release after the 3rd accepted beat; requester 0 is re-granted the next cycle.
- Owner 2 with credit 5: drop req[2] after 2 beats while req[0]=1 -> next cycle gnt=0001, gnt_id=0.
- weight1=0, req=0010 -> every grant lasts exactly 1 beat, and gnt_last=1 continuously.
- rst_b=0 for one edge mid-burst (owner 1, credit 3) -> all outputs 0 after that edge. When rst_b returns with req=1111, the first grant goes to requester 0.

Source files
------------

// File: rtl/wrr_burst_scheduler_if.sv
// Requester/resource handshake bundle for the weighted round-robin burst scheduler.
// The scheduler attaches through the slave modport; the requester/resource side uses master.
interface wrr_burst_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int WT_W    = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) ();
    logic [NUM_REQ-1:0]      req;
    logic [NUM_REQ*WT_W-1:0] weight;
    logic                    gnt_rdy;
    logic [NUM_REQ-1:0]      gnt;
    logic [ID_W-1:0]         gnt_id;
    logic                    gnt_vld;
    logic                    gnt_last;

    modport master (
        output req, weight, gnt_rdy,
        input  gnt, gnt_id, gnt_vld, gnt_last
    );

    modport slave (
        input  req, weight, gnt_rdy,
        output gnt, gnt_id, gnt_vld, gnt_last
    );
endinterface

// File: rtl/wrr_burst_scheduler.sv
// Weighted round-robin scheduler: the winner owns the resource for up to weight beats,
// then ownership rotates with the previous owner at lowest priority and no idle bubble.
module wrr_burst_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int WT_W    = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_b,
    wrr_burst_scheduler_if.slave bus
);
    typedef enum logic {IDLE, OWN} state_t;

    state_t          state_reg, state_next;
    logic [ID_W-1:0] owner_reg, owner_next;
    logic [ID_W-1:0] last_ptr_reg, last_ptr_next;
    logic [WT_W-1:0] credit_reg, credit_next;

    logic [ID_W-1:0]    arb_base;
    logic [NUM_REQ-1:0] rot_req;
    logic [ID_W-1:0]    rot_idx [NUM_REQ];
    logic               arb_found;
    logic [ID_W-1:0]    arb_win;
    logic [WT_W-1:0]    win_weight;
    logic [WT_W-1:0]    win_credit;
    logic               beat;
    logic               release_own;

    // While owning, the search starts after the current owner so a release hands over in the same cycle.
    assign arb_base = (state_reg == OWN) ? owner_reg : last_ptr_reg;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            logic [ID_W:0] idx_sum;
            logic [ID_W:0] idx_mod;
            assign idx_sum     = {1'b0, arb_base} + (ID_W+1)'(gi + 1);
            assign idx_mod     = (idx_sum >= (ID_W+1)'(NUM_REQ)) ? idx_sum - (ID_W+1)'(NUM_REQ) : idx_sum;
            assign rot_idx[gi] = ID_W'(idx_mod);
            assign rot_req[gi] = bus.req[rot_idx[gi]];
        end
    endgenerate

    always_comb begin
        arb_found = 1'b0;
        arb_win   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                arb_found = 1'b1;
                arb_win   = rot_idx[k];
            end
        end
    end

    // A zero weight still buys one beat so a requester can never be starved by its own setting.
    assign win_weight  = bus.weight[arb_win*WT_W +: WT_W];
    assign win_credit  = (win_weight == '0) ? WT_W'(1) : win_weight;
    assign beat        = (state_reg == OWN) && bus.gnt_rdy;
    assign release_own = (state_reg == OWN) &&
                         ((beat && (credit_reg == WT_W'(1))) || !bus.req[owner_reg]);

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_reg    <= IDLE;
            owner_reg    <= '0;
            credit_reg   <= '0;
            last_ptr_reg <= ID_W'(NUM_REQ - 1);
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            credit_reg   <= credit_next;
            last_ptr_reg <= last_ptr_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        credit_next   = credit_reg;
        last_ptr_next = last_ptr_reg;
        case (state_reg)
            IDLE: begin
                if (arb_found) begin
                    state_next  = OWN;
                    owner_next  = arb_win;
                    credit_next = win_credit;
                end
            end
            OWN: begin
                if (release_own) begin
                    last_ptr_next = owner_reg;
                    if (arb_found) begin
                        owner_next  = arb_win;
                        credit_next = win_credit;
                    end else begin
                        state_next  = IDLE;
                        credit_next = '0;
                    end
                end else if (beat) begin
                    credit_next = credit_reg - WT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.gnt      = '0;
        bus.gnt_id   = '0;
        bus.gnt_vld  = 1'b0;
        bus.gnt_last = 1'b0;
        if (state_reg == OWN) begin
            bus.gnt[owner_reg] = 1'b1;
            bus.gnt_id         = owner_reg;
            bus.gnt_vld        = 1'b1;
            bus.gnt_last       = (credit_reg == WT_W'(1));
        end
    end
endmodule

// File: tb/tb_wrr_burst_scheduler.sv
// Directed bench for wrr_burst_scheduler: per-cycle expected grants queued with the stimulus,
// then popped and compared one edge later.
module tb_wrr_burst_scheduler;
    localparam int NUM_REQ = 4;
    localparam int WT_W    = 4;
    localparam int ID_W    = 2;

    logic clk = 1'b0;
    logic rst_b;

    wrr_burst_scheduler_if #(.NUM_REQ(NUM_REQ), .WT_W(WT_W), .ID_W(ID_W)) bus ();

    wrr_burst_scheduler #(.NUM_REQ(NUM_REQ), .WT_W(WT_W), .ID_W(ID_W)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [4:0] sb [$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int step     = 0;

    function automatic logic [ID_W-1:0] enc(input logic [NUM_REQ-1:0] oh);
        logic [ID_W-1:0] r = '0;
        for (int i = 0; i < NUM_REQ; i++) if (oh[i]) r = ID_W'(i);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL step %0d %s: observed %0h expected %0h", step, tag, obs, exp);
        end
    endtask

    // Drive one cycle, queue what the registered outputs must show after the edge, then compare.
    task automatic cyc(input logic rb, input logic [3:0] rq, input logic rdy,
                       input logic [3:0] eg, input logic el);
        logic [4:0] e;
        rst_b       = rb;
        bus.req     = rq;
        bus.gnt_rdy = rdy;
        sb.push_back({eg, el});
        @(posedge clk);
        #1;
        step++;
        e = sb.pop_front();
        check("gnt",      32'(bus.gnt),      32'(e[4:1]));
        check("gnt_id",   32'(bus.gnt_id),   32'(enc(e[4:1])));
        check("gnt_vld",  32'(bus.gnt_vld),  32'(|e[4:1]));
        check("gnt_last", 32'(bus.gnt_last), 32'(e[0]));
        $display("step %0d rst_b=%0b req=%b rdy=%0b -> gnt=%b id=%0d last=%0b",
                 step, rb, rq, rdy, bus.gnt, bus.gnt_id, bus.gnt_last);
    endtask

    initial begin
        rst_b       = 1'b0;
        bus.req     = '0;
        bus.gnt_rdy = 1'b0;
        bus.weight  = {4'd2, 4'd2, 4'd2, 4'd2};

        // Reset state, then equal weights of 2 rotate through all four requesters.
        cyc(0, 4'b0000, 0, 4'b0000, 0);
        cyc(1, 4'b1111, 1, 4'b0001, 0);
        cyc(1, 4'b1111, 1, 4'b0001, 1);
        cyc(1, 4'b1111, 1, 4'b0010, 0);
        cyc(1, 4'b1111, 1, 4'b0010, 1);
        cyc(1, 4'b1111, 1, 4'b0100, 0);
        cyc(1, 4'b1111, 1, 4'b0100, 1);
        cyc(1, 4'b1111, 1, 4'b1000, 0);
        cyc(1, 4'b1111, 1, 4'b1000, 1);
        cyc(1, 4'b1111, 1, 4'b0001, 0);

        // Weights 1,2,3,4 give back-to-back bursts of matching length.
        bus.weight = {4'd4, 4'd3, 4'd2, 4'd1};
        cyc(0, 4'b0000, 0, 4'b0000, 0);
        cyc(1, 4'b1111, 1, 4'b0001, 1);
        cyc(1, 4'b1111, 1, 4'b0010, 0);
        cyc(1, 4'b1111, 1, 4'b0010, 1);
        cyc(1, 4'b1111, 1, 4'b0100, 0);
        cyc(1, 4'b1111, 1, 4'b0100, 0);
        cyc(1, 4'b1111, 1, 4'b0100, 1);
        cyc(1, 4'b1111, 1, 4'b1000, 0);
        cyc(1, 4'b1111, 1, 4'b1000, 0);
        cyc(1, 4'b1111, 1, 4'b1000, 0);
        cyc(1, 4'b1111, 1, 4'b1000, 1);
        cyc(1, 4'b1111, 1, 4'b0001, 1);

        // Sole requester, weight 3, toggling ready: credit holds on stalls, re-grant after 3rd beat.
        bus.weight = {4'd1, 4'd1, 4'd1, 4'd3};
        cyc(0, 4'b0000, 0, 4'b0000, 0);
        cyc(1, 4'b0001, 0, 4'b0001, 0);
        cyc(1, 4'b0001, 1, 4'b0001, 0);
        cyc(1, 4'b0001, 0, 4'b0001, 0);
        cyc(1, 4'b0001, 1, 4'b0001, 1);
        cyc(1, 4'b0001, 0, 4'b0001, 1);
        cyc(1, 4'b0001, 1, 4'b0001, 0);
        cyc(1, 4'b0001, 1, 4'b0001, 0);

        // Owner 2 with credit 5 drops its request after two beats; requester 0 takes over at once.
        bus.weight = {4'd1, 4'd5, 4'd1, 4'd3};
        cyc(0, 4'b0000, 0, 4'b0000, 0);
        cyc(1, 4'b0100, 1, 4'b0100, 0);
        cyc(1, 4'b0101, 1, 4'b0100, 0);
        cyc(1, 4'b0101, 1, 4'b0100, 0);
        cyc(1, 4'b0001, 1, 4'b0001, 0);
        cyc(1, 4'b0001, 1, 4'b0001, 0);
        cyc(1, 4'b0000, 1, 4'b0000, 0);

        // Zero weight behaves as one: single-beat grants with gnt_last held high.
        bus.weight = {4'd2, 4'd2, 4'd0, 4'd2};
        cyc(0, 4'b0000, 0, 4'b0000, 0);
        cyc(1, 4'b0010, 1, 4'b0010, 1);
        cyc(1, 4'b0010, 1, 4'b0010, 1);
        cyc(1, 4'b0010, 0, 4'b0010, 1);
        cyc(1, 4'b0010, 1, 4'b0010, 1);

        // Reset mid-burst (owner 1, credit 3) clears everything; requester 0 wins afterwards,
        // and a weight change during its burst does not stretch it.
        bus.weight = {4'd2, 4'd2, 4'd3, 4'd2};
        cyc(0, 4'b0000, 0, 4'b0000, 0);
        cyc(1, 4'b0010, 0, 4'b0010, 0);
        cyc(0, 4'b1111, 1, 4'b0000, 0);
        cyc(1, 4'b1111, 1, 4'b0001, 0);
        bus.weight = {4'd2, 4'd2, 4'd3, 4'd7};
        cyc(1, 4'b1111, 1, 4'b0001, 1);
        cyc(1, 4'b1111, 1, 4'b0010, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
